// File: rtl/riscv_defines.sv
// Shared core definitions: ALU opcodes and the divide front-end state type.
package riscv_defines;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_ISSUE,
    DIV_WAIT,
    DIV_DRAIN,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/riscv_div_special.sv
// Decodes a divide op and resolves the RISC-V divide-by-zero and signed
// overflow cases without involving the iterative divider.
module riscv_div_special
  import riscv_defines::*;
(
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_a_i,
  input  logic [31:0]             operand_b_i,
  output logic                    is_special,
  output logic [31:0]             special_result,
  output logic                    is_signed,
  output logic                    sel_rem
);

  logic b_zero, ovf;

  assign is_signed = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
  assign sel_rem   = (operator_i == ALU_REM) || (operator_i == ALU_REMU);
  assign b_zero    = (operand_b_i == 32'h0);
  assign ovf       = is_signed && (operand_a_i == 32'h8000_0000) &&
                     (operand_b_i == 32'hFFFF_FFFF);

  assign is_special = b_zero || ovf;

  // Divide-by-zero takes priority; the overflow quotient equals the dividend.
  always_comb begin
    special_result = 32'h0;
    if (b_zero)
      special_result = sel_rem ? operand_a_i : 32'hFFFF_FFFF;
    else if (ovf)
      special_result = sel_rem ? 32'h0 : 32'h8000_0000;
  end

endmodule

// File: rtl/riscv_div_ctrl.sv
// EX-stage divide sequencer: handles special cases locally, otherwise issues
// to the multi-cycle divider core and holds the result until EX takes it.
module riscv_div_ctrl
  import riscv_defines::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_en_i,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_a_i,
  input  logic [31:0]             operand_b_i,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  output logic                    ready_o,
  output logic [31:0]             result_o,
  output logic                    dvd_valid_o,
  input  logic                    dvd_ready_i,
  output logic [31:0]             dvd_dividend_o,
  output logic [31:0]             dvd_divisor_o,
  output logic                    dvd_signed_o,
  input  logic                    dvd_done_i,
  input  logic [31:0]             dvd_quot_i,
  input  logic [31:0]             dvd_rem_i
);

  div_state_t  state_q, state_d;
  logic        sel_rem_q;
  logic        accept;
  logic        is_special, is_signed, sel_rem;
  logic [31:0] special_result;

  riscv_div_special u_special (
    .operator_i     (operator_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .is_special     (is_special),
    .special_result (special_result),
    .is_signed      (is_signed),
    .sel_rem        (sel_rem)
  );

  assign accept = (state_q == DIV_IDLE) && div_en_i && !flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE:  if (accept) state_d = is_special ? DIV_DONE : DIV_ISSUE;
      DIV_ISSUE: begin
        if (flush_i)          state_d = DIV_IDLE;
        else if (dvd_ready_i) state_d = DIV_WAIT;
      end
      // The core cannot be cancelled, so a flushed op must still be drained.
      DIV_WAIT: begin
        if (flush_i)         state_d = dvd_done_i ? DIV_IDLE : DIV_DRAIN;
        else if (dvd_done_i) state_d = DIV_DONE;
      end
      DIV_DRAIN: if (dvd_done_i) state_d = DIV_IDLE;
      DIV_DONE:  if (flush_i || ex_ready_i) state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= DIV_IDLE;
      result_o       <= 32'h0;
      dvd_dividend_o <= 32'h0;
      dvd_divisor_o  <= 32'h0;
      dvd_signed_o   <= 1'b0;
      sel_rem_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dvd_dividend_o <= operand_a_i;
        dvd_divisor_o  <= operand_b_i;
        dvd_signed_o   <= is_signed;
        sel_rem_q      <= sel_rem;
        if (is_special) result_o <= special_result;
      end else if (state_q == DIV_WAIT && dvd_done_i && !flush_i) begin
        result_o <= sel_rem_q ? dvd_rem_i : dvd_quot_i;
      end
    end
  end

  // Flush withdraws an un-accepted issue in the same cycle.
  assign dvd_valid_o = (state_q == DIV_ISSUE) && !flush_i;
  assign ready_o     = (state_q == DIV_DONE) || ((state_q == DIV_IDLE) && !div_en_i);

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Randomized self-checking bench for riscv_div_ctrl with a behavioural
// divider-core model and an arithmetic reference for RISC-V divide results.
module tb_riscv_div_ctrl;
  import riscv_defines::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    div_en_i, flush_i, ex_ready_i;
  logic [ALU_OP_WIDTH-1:0] operator_i;
  logic [31:0]             operand_a_i, operand_b_i;
  logic                    ready_o, dvd_valid_o, dvd_signed_o;
  logic [31:0]             result_o, dvd_dividend_o, dvd_divisor_o;
  logic                    dvd_ready_i, dvd_done_i;
  logic [31:0]             dvd_quot_i, dvd_rem_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_div_ctrl dut (
    .clk(clk), .rst(rst), .div_en_i(div_en_i), .operator_i(operator_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .flush_i(flush_i),
    .ex_ready_i(ex_ready_i), .ready_o(ready_o), .result_o(result_o),
    .dvd_valid_o(dvd_valid_o), .dvd_ready_i(dvd_ready_i),
    .dvd_dividend_o(dvd_dividend_o), .dvd_divisor_o(dvd_divisor_o),
    .dvd_signed_o(dvd_signed_o), .dvd_done_i(dvd_done_i),
    .dvd_quot_i(dvd_quot_i), .dvd_rem_i(dvd_rem_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [6:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit is_rem, sgn;
    is_rem = (op == ALU_REM) || (op == ALU_REMU);
    sgn    = (op == ALU_DIV) || (op == ALU_REM);
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return is_rem ? a % b : a / b;
  endfunction

  function automatic bit ref_special(input logic [6:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sgn;
    sgn = (op == ALU_DIV) || (op == ALU_REM);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Divider core model: ready after core_hold valid cycles, done core_lat
  // cycles after the handshake, occasional stray done pulses while idle.
  int          core_hold = 0, core_lat = 0, core_cnt = 0;
  bit          core_busy = 0;
  logic [31:0] core_q, core_r;

  initial begin
    dvd_ready_i = 0; dvd_done_i = 0; dvd_quot_i = 0; dvd_rem_i = 0;
    forever begin
      @(negedge clk); #1;
      dvd_done_i = 0; dvd_ready_i = 0;
      if (rst) core_busy = 0;
      else if (core_busy) begin
        if (core_cnt == 0) begin
          dvd_done_i = 1; dvd_quot_i = core_q; dvd_rem_i = core_r; core_busy = 0;
        end else core_cnt--;
      end else begin
        if ($urandom_range(0, 15) == 0) begin
          dvd_done_i = 1; dvd_quot_i = $urandom; dvd_rem_i = $urandom;
        end
        if (dvd_valid_o) begin
          if (core_hold > 0) core_hold--;
          else dvd_ready_i = 1;
        end
        if (dvd_valid_o && dvd_ready_i) begin
          core_busy = 1; core_cnt = core_lat;
          if (dvd_divisor_o == 0) begin
            core_q = 32'hDEAD_BEEF; core_r = 32'hDEAD_BEEF;
          end else if (dvd_signed_o &&
                       !(dvd_dividend_o == 32'h8000_0000 && dvd_divisor_o == 32'hFFFF_FFFF)) begin
            core_q = 32'($signed(dvd_dividend_o) / $signed(dvd_divisor_o));
            core_r = 32'($signed(dvd_dividend_o) % $signed(dvd_divisor_o));
          end else begin
            core_q = dvd_dividend_o / dvd_divisor_o;
            core_r = dvd_dividend_o % dvd_divisor_o;
          end
        end
      end
    end
  end

  // Called just after a falling edge; returns just after a falling edge with
  // the DUT back in IDLE.
  task automatic run_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int lat, input int exdly);
    logic [31:0] exp;
    bit          spec, sgn, prev_done;
    int          n;
    exp  = ref_result(op, a, b);
    spec = ref_special(op, a, b);
    sgn  = (op == ALU_DIV) || (op == ALU_REM);
    core_hold = hold; core_lat = lat;
    div_en_i = 1; operator_i = op; operand_a_i = a; operand_b_i = b;
    #2 chk("ready_low_on_request", 32'(ready_o), 32'd0);
    @(negedge clk);
    div_en_i = 0; operator_i = ALU_DIVU; operand_a_i = $urandom; operand_b_i = $urandom;
    #2;
    chk("latched_dividend", dvd_dividend_o, a);
    chk("latched_divisor", dvd_divisor_o, b);
    if (spec) begin
      chk("special_ready_t1", 32'(ready_o), 32'd1);
      chk("special_no_issue", 32'(dvd_valid_o), 32'd0);
    end else begin
      chk("issue_valid_t1", 32'(dvd_valid_o), 32'd1);
      chk("issue_signed", 32'(dvd_signed_o), 32'(sgn));
      prev_done = 0; n = 0;
      while (!ready_o && n < 300) begin
        if (dvd_valid_o) begin
          chk("issue_dividend_stable", dvd_dividend_o, a);
          chk("issue_divisor_stable", dvd_divisor_o, b);
        end
        prev_done = dvd_done_i;
        @(negedge clk); #2; n++;
      end
      if (n >= 300) chk("ready_timeout", 32'(ready_o), 32'd1);
      else chk("ready_follows_done", 32'(prev_done), 32'd1);
    end
    chk("result", result_o, exp);
    for (int i = 0; i < exdly; i++) begin
      @(negedge clk); #2;
      chk("result_held", result_o, exp);
      chk("ready_held", 32'(ready_o), 32'd1);
    end
    ex_ready_i = 1;
    @(negedge clk);
    ex_ready_i = 0;
  endtask

  function automatic logic [6:0] rand_op();
    case ($urandom_range(0, 3))
      0: return ALU_DIV;
      1: return ALU_DIVU;
      2: return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  initial begin
    logic [31:0] old_res, old_a, a, b;
    bit          seen;
    int          n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_res, old_a, a, b;
    bit          seen;
    int          n;
    rst = 1; div_en_i = 0; flush_i = 0; ex_ready_i = 0;
    operator_i = ALU_DIVU; operand_a_i = 0; operand_b_i = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #2;
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_result", result_o, 32'h0);
    chk("reset_valid", 32'(dvd_valid_o), 32'd0);
    chk("reset_dividend", dvd_dividend_o, 32'h0);
    chk("reset_divisor", dvd_divisor_o, 32'h0);
    chk("reset_signed", 32'(dvd_signed_o), 32'd0);
    @(negedge clk);

    run_op(ALU_DIVU, 32'd100, 32'd7, 0, 33, 0);
    run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 1, 5, 1);
    run_op(ALU_DIV, 32'd5, 32'd0, 0, 3, 0);
    run_op(ALU_REMU, 32'd5, 32'd0, 0, 3, 0);
    run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3, 0);
    run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3, 0);
    run_op(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 4, 6, 5);

    // Issue held off by the core, then withdrawn by a flush.
    core_hold = 4; core_lat = 3;
    div_en_i = 1; operator_i = ALU_DIV; operand_a_i = 32'd12345; operand_b_i = 32'hFFFF_FFEF;
    @(negedge clk);
    div_en_i = 0;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("held_issue_valid", 32'(dvd_valid_o), 32'd1);
      chk("held_issue_dividend", dvd_dividend_o, 32'd12345);
      @(negedge clk);
    end
    flush_i = 1;
    #2 chk("flush_withdraws_issue", 32'(dvd_valid_o), 32'd0);
    @(negedge clk);
    flush_i = 0;
    #2;
    chk("flush_issue_to_idle", 32'(ready_o), 32'd1);
    chk("flush_issue_no_valid", 32'(dvd_valid_o), 32'd0);
    @(negedge clk);

    // Flush coinciding with a request blocks the accept.
    old_a = dvd_dividend_o;
    div_en_i = 1; flush_i = 1; operator_i = ALU_DIVU; operand_a_i = 32'd999; operand_b_i = 32'd4;
    @(negedge clk);
    div_en_i = 0; flush_i = 0;
    #2;
    chk("flush_blocks_accept_valid", 32'(dvd_valid_o), 32'd0);
    chk("flush_blocks_accept_ready", 32'(ready_o), 32'd1);
    chk("flush_blocks_accept_data", dvd_dividend_o, old_a);
    @(negedge clk);

    // Flush while the core is busy: new request waits for the stale done.
    run_op(ALU_DIVU, 32'd50, 32'd7, 0, 2, 0);
    core_hold = 0; core_lat = 15;
    div_en_i = 1; operator_i = ALU_DIVU; operand_a_i = 32'd1000; operand_b_i = 32'd3;
    @(negedge clk);
    div_en_i = 0;
    repeat (3) @(negedge clk);
    flush_i = 1; old_res = result_o;
    @(negedge clk);
    flush_i = 0;
    div_en_i = 1; operator_i = ALU_DIV; operand_a_i = 32'hFFFF_FF9C; operand_b_i = 32'd7;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      #2;
      chk("drain_no_issue", 32'(dvd_valid_o), 32'd0);
      chk("drain_ready_low", 32'(ready_o), 32'd0);
      chk("drain_result_unchanged", result_o, old_res);
      seen = dvd_done_i;
      @(negedge clk); n++;
    end
    if (!seen) chk("drain_timeout", 32'(seen), 32'd1);
    #1 chk("stale_result_discarded", result_o, old_res);
    run_op(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 0, 4, 0);

    // Reset while the core is busy.
    core_hold = 0; core_lat = 30;
    div_en_i = 1; operator_i = ALU_REMU; operand_a_i = 32'd77; operand_b_i = 32'd10;
    @(negedge clk);
    div_en_i = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #2;
    chk("rst_wait_ready", 32'(ready_o), 32'd1);
    chk("rst_wait_result", result_o, 32'h0);
    chk("rst_wait_valid", 32'(dvd_valid_o), 32'd0);
    chk("rst_wait_dividend", dvd_dividend_o, 32'h0);
    chk("rst_wait_divisor", dvd_divisor_o, 32'h0);
    chk("rst_wait_signed", 32'(dvd_signed_o), 32'd0);
    @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        3: b = 32'($signed($urandom_range(0, 40)) - 20);
        default: ;
      endcase
      run_op(rand_op(), a, b, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
